eq_band_mixer: RTL and testbench

Downstream of the per-band FIR filters (low/mid/high) in the audio equalizer datapath. On each audio sample strobe it captures the `N_BAND` filtered band samples and per-band gains. It computes the gain-weighted sum with one time-shared multiplier driven by a small state machine. It then rounds and saturates the sum back to the 24-bit sample width and presents one output sample with a one-cycle valid pulse.

---
 rtl/eq_band_mixer.sv | 149 ++++++++++++++
 tb/tb_eq_band_mixer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// -----------------------------------------------------------------------------
// eq_band_mixer
//
// Gain-weighted mixer for the per-band FIR outputs of the audio equalizer.
// A sample strobe captures all band samples and their Q4.12 gains into shadow
// registers. One time-shared multiplier then accumulates band*gain over
// N_BAND cycles. The sum is rounded back to Q0 (round-half-up) and reduced to
// WD_OUT bits. The result is presented with a one-cycle valid pulse.
//
// Optional feature macro: EQ_MIX_SAT_EN
//   defined   : the rounded sum is clamped to the signed WD_OUT range, and
//               sat_o flags a clipped result.
//   undefined : the low WD_OUT bits are taken (two's-complement wrap), and
//               sat_o is tied to 0.
//
// Ports
//   clk             in   clock, rising-edge
//   reset           in   asynchronous, active-high reset
//   sample_valid_i  in   one-cycle capture strobe (ignored while busy)
//   band_i          in   packed signed band samples, band b at [b*WD_IN +: WD_IN]
//   gain_i          in   packed signed Q4.12 gains, same packing
//   data_out        out  signed mixed sample; holds between valids
//   data_valid_o    out  one-cycle pulse when data_out updates
//   busy_o          out  high while a mix is in progress
//   sat_o           out  pulses with data_valid_o when the result was clipped
// -----------------------------------------------------------------------------
module eq_band_mixer #(
    parameter int WD_IN   = 24,
    parameter int WD_OUT  = 24,
    parameter int GAIN_WD = 16,
    parameter int N_BAND  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid_i,
    input  logic [N_BAND*WD_IN-1:0]   band_i,
    input  logic [N_BAND*GAIN_WD-1:0] gain_i,
    output logic [WD_OUT-1:0]         data_out,
    output logic                      data_valid_o,
    output logic                      busy_o,
    output logic                      sat_o
);

    localparam int PROD_W = WD_IN + GAIN_WD;
    // Headroom bits make N_BAND full-scale products impossible to overflow.
    localparam int ACC_W  = PROD_W + $clog2(N_BAND) + 1;
    localparam int IDX_W  = (N_BAND > 1) ? $clog2(N_BAND) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BAND - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2048);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic signed [WD_IN-1:0]   band_sh [N_BAND];
    logic signed [GAIN_WD-1:0] gain_sh [N_BAND];
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod;

    // Q4.12 -> Q0 with round-half-up: add half an LSB, then floor via >>>.
    function automatic logic signed [ACC_W-1:0] round_q12(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> 12;
    endfunction

`ifdef EQ_MIX_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (WD_OUT - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    function automatic logic clip_flag(input logic signed [ACC_W-1:0] r);
        return (r > OUT_MAX) || (r < OUT_MIN);
    endfunction

    function automatic logic [WD_OUT-1:0] sat_out(input logic signed [ACC_W-1:0] r);
        if (r > OUT_MAX)
            return OUT_MAX[WD_OUT-1:0];
        else if (r < OUT_MIN)
            return OUT_MIN[WD_OUT-1:0];
        else
            return r[WD_OUT-1:0];
    endfunction

    logic signed [ACC_W-1:0] rnd;
    assign rnd = round_q12(acc);
`else
    // Wrap mode keeps only the low bits of the rounded sum.
    logic [WD_OUT-1:0] rnd;
    assign rnd = WD_OUT'(round_q12(acc));
`endif

    // The single shared multiplier sees whichever band the index selects.
    assign prod = band_sh[idx] * gain_sh[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            data_out     <= '0;
            data_valid_o <= 1'b0;
            sat_o        <= 1'b0;
            busy_o       <= 1'b0;
            for (int b = 0; b < N_BAND; b++) begin
                band_sh[b] <= '0;
                gain_sh[b] <= '0;
            end
        end else begin
            data_valid_o <= 1'b0;
            sat_o        <= 1'b0;
            case (state)
                // Capture stage: snapshot inputs so later input changes cannot leak in.
                IDLE: begin
                    if (sample_valid_i) begin
                        for (int b = 0; b < N_BAND; b++) begin
                            band_sh[b] <= band_i[b*WD_IN +: WD_IN];
                            gain_sh[b] <= gain_i[b*GAIN_WD +: GAIN_WD];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= MAC;
                    end
                end
                // Accumulate stage: one band per cycle.
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == LAST_IDX)
                        state <= ROUND;
                    else
                        idx <= idx + IDX_W'(1);
                end
                // Output stage: round, reduce, publish.
                ROUND: begin
`ifdef EQ_MIX_SAT_EN
                    data_out <= sat_out(rnd);
                    sat_o    <= clip_flag(rnd);
`else
                    data_out <= rnd;
                    sat_o    <= 1'b0;
`endif
                    data_valid_o <= 1'b1;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
module tb_eq_band_mixer;

    localparam int N   = 3;
    localparam int WI  = 24;
    localparam int WO  = 24;
    localparam int GW  = 16;
    localparam int LAT = N + 1;
    localparam int GAP = N + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            sample_valid_i;
    logic [N*WI-1:0] band_i;
    logic [N*GW-1:0] gain_i;
    logic [WO-1:0]   data_out;
    logic            data_valid_o;
    logic            busy_o;
    logic            sat_o;

    eq_band_mixer #(.WD_IN(WI), .WD_OUT(WO), .GAIN_WD(GW), .N_BAND(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid_i (sample_valid_i),
        .band_i         (band_i),
        .gain_i         (gain_i),
        .data_out       (data_out),
        .data_valid_o   (data_valid_o),
        .busy_o         (busy_o),
        .sat_o          (sat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WO-1:0] data;
        bit            sat;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    int            last_acc = -1000;
    logic [WO-1:0] last_out = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: exact integer weighted sum, then round/reduce by plain arithmetic.
    function automatic void model(input logic [N*WI-1:0] b, input logic [N*GW-1:0] g,
                                  output logic [WO-1:0] v, output bit s);
        longint sum = 0;
        longint r;
        longint mx = (longint'(1) <<< (WO - 1)) - 1;
        longint mn = -mx - 1;
        for (int i = 0; i < N; i++)
            sum += longint'($signed(b[i*WI +: WI])) * longint'($signed(g[i*GW +: GW]));
        r = (sum + 2048) >>> 12;
`ifdef EQ_MIX_SAT_EN
        s = 1'b0;
        if (r > mx) begin
            r = mx;
            s = 1'b1;
        end else if (r < mn) begin
            r = mn;
            s = 1'b1;
        end
        v = r[WO-1:0];
`else
        v = r[WO-1:0];
        s = 1'b0;
`endif
    endfunction

    function automatic logic [N*WI-1:0] pkb(input logic [WI-1:0] b0, input logic [WI-1:0] b1,
                                            input logic [WI-1:0] b2);
        return {b2, b1, b0};
    endfunction

    function automatic logic [N*GW-1:0] pkg3(input logic [GW-1:0] g0, input logic [GW-1:0] g1,
                                             input logic [GW-1:0] g2);
        return {g2, g1, g0};
    endfunction

    function automatic logic [N*WI-1:0] rand_band();
        logic [N*WI-1:0] b;
        for (int i = 0; i < N; i++) b[i*WI +: WI] = WI'($urandom);
        return b;
    endfunction

    function automatic logic [N*GW-1:0] rand_gain();
        logic [N*GW-1:0] g;
        for (int i = 0; i < N; i++) g[i*GW +: GW] = GW'($urandom);
        return g;
    endfunction

    // Drives one cycle of inputs; a strobe is accepted when the mixer is idle,
    // i.e. at least GAP edges after the previous accepted strobe.
    task automatic drive(input bit stb, input logic [N*WI-1:0] b, input logic [N*GW-1:0] g);
        logic [WO-1:0] v;
        bit            s;
        @(negedge clk);
        sample_valid_i = stb;
        band_i         = b;
        gain_i         = g;
        if (stb && (cyc + 1 - last_acc >= GAP)) begin
            model(b, g, v, s);
            q.push_back('{data: v, sat: s, cyc: cyc + 1 + LAT});
            last_acc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, rand_band(), rand_gain());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        sample_valid_i = 1'b0;
        q.delete();
        last_acc = -1000;
        last_out = '0;
        #1;
        chk("reset_data_out", data_out, 0);
        chk("reset_valid", data_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_sat", sat_o, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1 && data_valid_o === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", data_out, e.data);
                    chk("sat", sat_o, e.sat);
                    chk("latency", cyc, e.cyc);
                    last_out = e.data;
                end
            end else begin
                chk("sat_without_valid", sat_o, 0);
            end
            chk("data_hold", data_out, last_out);
            chk("busy", busy_o, (cyc >= last_acc && cyc < last_acc + LAT) ? 1 : 0);
        end
    end

    initial begin
        logic [N*GW-1:0] unity;
        unity          = pkg3(16'h1000, 16'h1000, 16'h1000);
        reset          = 1'b1;
        sample_valid_i = 1'b0;
        band_i         = '0;
        gain_i         = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_data_out", data_out, 0);
        chk("init_valid", data_valid_o, 0);
        chk("init_busy", busy_o, 0);
        chk("init_sat", sat_o, 0);
        reset = 1'b0;

        // Unity mix
        drive(1'b1, pkb(24'h000100, 24'h000200, 24'h000300), unity);
        idle(6);
        // Rounding, both signs
        drive(1'b1, pkb(24'h000003, 24'h0, 24'h0), pkg3(16'h0800, 16'h0, 16'h0));
        idle(6);
        drive(1'b1, pkb(24'hFFFFFD, 24'h0, 24'h0), pkg3(16'h0800, 16'h0, 16'h0));
        idle(6);
        // Clipping, positive and negative full scale
        drive(1'b1, pkb(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF), unity);
        idle(6);
        drive(1'b1, pkb(24'h800000, 24'h800000, 24'h800000), unity);
        idle(6);
        // Negative gain (phase inversion) at the gain range limit
        drive(1'b1, pkb(24'h001000, 24'h000010, 24'h0), pkg3(16'h8000, 16'h7FFF, 16'h0));
        idle(6);
        // Busy drop: strobes at k+2 and k+4 ignored, k+5 accepted
        drive(1'b1, pkb(24'h000111, 24'h000222, 24'h000333), unity);
        idle(1);
        drive(1'b1, pkb(24'h7FFFFF, 24'h123456, 24'h654321), unity);
        idle(1);
        drive(1'b1, pkb(24'h0ABCDE, 24'h0, 24'h0), unity);
        drive(1'b1, pkb(24'h000010, 24'h000020, 24'h000030), unity);
        idle(6);
        // Mid-operation reset between edges k+2 and k+3
        drive(1'b1, pkb(24'h000400, 24'h000500, 24'h000600), unity);
        idle(2);
        do_reset();
        idle(2);
        drive(1'b1, pkb(24'h000100, 24'h000200, 24'h000300), unity);
        idle(6);
        // Capture isolation: idle() changes band_i/gain_i right after capture
        drive(1'b1, pkb(24'h010000, 24'hFF0000, 24'h000001), pkg3(16'h2000, 16'h1000, 16'hF000));
        idle(6);

        // Randomized traffic with back-to-back pressure and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0)
                do_reset();
            else
                drive(($urandom_range(0, 2) == 0), rand_band(), rand_gain());
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
        idle(2);
        chk("drain_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
